pipeline_controller: RTL and testbench

- Central hazard and sequencing unit for the 5-stage pipeline.
- Drives the enable and flush inputs of the four pipeline latches (fetch, decode, execute, memory) and the PC enable.
- Resolves memory stalls, load-use hazards, taken branches/jumps and halt drain.
- Keeps saturating performance counters for stall and flush events.

---
 rtl/pipeline_controller.sv | 164 ++++++++++++++++
 tb/tb_pipeline_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
//   Hazard and sequencing unit for the 5-stage pipeline.
//   It generates the enable and flush signals for the fetch, decode, execute
//   and memory latches, and it drives the PC enable. It resolves data-memory
//   stalls, load-use hazards, taken redirects and the HALT drain sequence.
//   It also keeps saturating counters for stall cycles and redirect flushes.
//
// Ports
//   CLK, nRST                    clock, asynchronous active-low reset
//   ihit, dhit                   instruction fetch / data access complete
//   mem_dREN, mem_dWEN           MEM-stage data memory read / write
//   mem_halt, mem_redirect       HALT / taken branch-jump in MEM
//   ex_dREN, ex_Rt               EX-stage load and its destination register
//   id_Rs, id_Rt, id_uses_Rt     decode source registers, Rt-used flag
//   pc_en                        PC update enable
//   fl/dl/el/ml_en               latch enables
//   fl/dl/el/ml_flush            latch flushes (flush beats enable)
//   halt                         sticky halted flag (registered)
//   stall_cycles, flush_events   saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_controller #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             mem_halt,
   input  logic             mem_redirect,
   input  logic             ex_dREN,
   input  logic [4:0]       ex_Rt,
   input  logic [4:0]       id_Rs,
   input  logic [4:0]       id_Rt,
   input  logic             id_uses_Rt,
   output logic             pc_en,
   output logic             fl_en,
   output logic             dl_en,
   output logic             el_en,
   output logic             ml_en,
   output logic             fl_flush,
   output logic             dl_flush,
   output logic             el_flush,
   output logic             ml_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] DRAIN  = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0] state, state_n;
   logic       dstall, lu;
   logic       halt_entry;
   logic       stall_inc, flush_inc;

   // Outputs before reset gating.
   logic pc_c, fl_en_c, dl_en_c, el_en_c, ml_en_c;
   logic fl_fl_c, dl_fl_c, el_fl_c, ml_fl_c;

   assign dstall = (mem_dREN | mem_dWEN) & ~dhit;
   assign lu     = ex_dREN & (ex_Rt != 5'd0) &
                   ((ex_Rt == id_Rs) | (id_uses_Rt & (ex_Rt == id_Rt)));

   always_comb begin
      state_n    = state;
      pc_c       = 1'b0;
      fl_en_c    = 1'b0;
      dl_en_c    = 1'b0;
      el_en_c    = 1'b0;
      ml_en_c    = 1'b0;
      fl_fl_c    = 1'b0;
      dl_fl_c    = 1'b0;
      el_fl_c    = 1'b0;
      ml_fl_c    = 1'b0;
      halt_entry = 1'b0;
      flush_inc  = 1'b0;
      case (state)
         RUN: begin
            if (dstall) begin
               // Freeze everything and send a bubble into WB.
               ml_fl_c = 1'b1;
            end else if (mem_halt) begin
               // HALT wins over a same-cycle redirect. The redirect is not counted.
               halt_entry = 1'b1;
               ml_en_c    = 1'b1;
               fl_fl_c    = 1'b1;
               dl_fl_c    = 1'b1;
               el_fl_c    = 1'b1;
               state_n    = DRAIN;
            end else if (mem_redirect) begin
               // The flushes repeat every cycle until the redirected fetch lands.
               fl_fl_c   = 1'b1;
               dl_fl_c   = 1'b1;
               el_fl_c   = 1'b1;
               ml_en_c   = 1'b1;
               pc_c      = ihit;
               flush_inc = ihit;
            end else if (lu) begin
               // Hold the fetch latch instead of flushing it, so the fetched
               // word survives even if ihit is low.
               dl_fl_c = 1'b1;
               el_en_c = 1'b1;
               ml_en_c = 1'b1;
            end else if (!ihit) begin
               fl_fl_c = 1'b1;
               dl_en_c = 1'b1;
               el_en_c = 1'b1;
               ml_en_c = 1'b1;
            end else begin
               pc_c    = 1'b1;
               fl_en_c = 1'b1;
               dl_en_c = 1'b1;
               el_en_c = 1'b1;
               ml_en_c = 1'b1;
            end
         end
         DRAIN: begin
            ml_fl_c = 1'b1;
            state_n = HALTED;
         end
         HALTED: begin
            state_n = HALTED;
         end
         default: begin
            state_n = RUN;
         end
      endcase
   end

   assign stall_inc = (state == RUN) & ~pc_c & ~halt_entry;

   // Hold every control output low while reset is asserted.
   assign pc_en    = nRST & pc_c;
   assign fl_en    = nRST & fl_en_c;
   assign dl_en    = nRST & dl_en_c;
   assign el_en    = nRST & el_en_c;
   assign ml_en    = nRST & ml_en_c;
   assign fl_flush = nRST & fl_fl_c;
   assign dl_flush = nRST & dl_fl_c;
   assign el_flush = nRST & el_fl_c;
   assign ml_flush = nRST & ml_fl_c;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state        <= RUN;
         halt         <= 1'b0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state <= state_n;
         halt  <= (state_n == HALTED);
         if (stall_inc && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if (flush_inc && (flush_events != '1))
            flush_events <= flush_events + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       ihit = 1'b0, dhit = 1'b0;
   logic       mem_dREN = 1'b0, mem_dWEN = 1'b0, mem_halt = 1'b0, mem_redirect = 1'b0;
   logic       ex_dREN = 1'b0, id_uses_Rt = 1'b0;
   logic [4:0] ex_Rt = '0, id_Rs = '0, id_Rt = '0;

   logic        pc_a, fle_a, dle_a, ele_a, mle_a, flf_a, dlf_a, elf_a, mlf_a, halt_a;
   logic        pc_b, fle_b, dle_b, ele_b, mle_b, flf_b, dlf_b, elf_b, mlf_b, halt_b;
   logic [31:0] stall_a, flush_a;
   logic [3:0]  stall_b, flush_b;

   int vectors = 0;
   int errors  = 0;

   // Bundle order: {pc_en, fl_en, dl_en, el_en, ml_en, fl_flush, dl_flush, el_flush, ml_flush}
   localparam logic [8:0] O_ZERO   = 9'b0_0000_0000;
   localparam logic [8:0] O_NORMAL = 9'b1_1111_0000;
   localparam logic [8:0] O_DSTALL = 9'b0_0000_0001;
   localparam logic [8:0] O_LU     = 9'b0_0011_0100;
   localparam logic [8:0] O_NOIHIT = 9'b0_0111_1000;
   localparam logic [8:0] O_REDIR1 = 9'b1_0001_1110;
   localparam logic [8:0] O_REDIR0 = 9'b0_0001_1110;
   localparam logic [8:0] O_HENTRY = 9'b0_0001_1110;
   localparam logic [8:0] O_DRAIN  = 9'b0_0000_0001;

   wire [8:0] obs_a = {pc_a, fle_a, dle_a, ele_a, mle_a, flf_a, dlf_a, elf_a, mlf_a};
   wire [8:0] obs_b = {pc_b, fle_b, dle_b, ele_b, mle_b, flf_b, dlf_b, elf_b, mlf_b};

   pipeline_controller u_dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
      .mem_redirect(mem_redirect), .ex_dREN(ex_dREN), .ex_Rt(ex_Rt),
      .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_Rt(id_uses_Rt),
      .pc_en(pc_a), .fl_en(fle_a), .dl_en(dle_a), .el_en(ele_a), .ml_en(mle_a),
      .fl_flush(flf_a), .dl_flush(dlf_a), .el_flush(elf_a), .ml_flush(mlf_a),
      .halt(halt_a), .stall_cycles(stall_a), .flush_events(flush_a)
   );

   pipeline_controller #(.CNT_W(4)) u_sat (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
      .mem_redirect(mem_redirect), .ex_dREN(ex_dREN), .ex_Rt(ex_Rt),
      .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_Rt(id_uses_Rt),
      .pc_en(pc_b), .fl_en(fle_b), .dl_en(dle_b), .el_en(ele_b), .ml_en(mle_b),
      .fl_flush(flf_b), .dl_flush(dlf_b), .el_flush(elf_b), .ml_flush(mlf_b),
      .halt(halt_b), .stall_cycles(stall_b), .flush_events(flush_b)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Check the combinational outputs mid-cycle, then advance to 1 ns after the next edge.
   task automatic vec(input string tag, input logic [8:0] exp);
      #2;
      chk({tag, "/ctl"}, {23'd0, obs_a}, {23'd0, exp});
      chk({tag, "/ctl4"}, {23'd0, obs_b}, {23'd0, exp});
      @(posedge CLK); #1;
   endtask

   task automatic chk_cnt(input string tag, input int st, input int st4,
                          input int fe, input int fe4);
      chk({tag, "/stall"}, stall_a, st);
      chk({tag, "/stall4"}, {28'd0, stall_b}, st4);
      chk({tag, "/flush"}, flush_a, fe);
      chk({tag, "/flush4"}, {28'd0, flush_b}, fe4);
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
      mem_halt = 1'b0; mem_redirect = 1'b0; ex_dREN = 1'b0;
      ex_Rt = '0; id_Rs = '0; id_Rt = '0; id_uses_Rt = 1'b0;
   endtask

   initial begin
      // Reset state. The outputs stay low even while inputs request progress.
      idle();
      #13;
      chk("rst_ctl", {23'd0, obs_a}, {23'd0, O_ZERO});
      chk("rst_halt", {31'd0, halt_a}, 32'd0);
      chk_cnt("rst", 0, 0, 0, 0);
      nRST = 1'b1;
      @(posedge CLK); #1;

      // Free-running with no hazards.
      for (int i = 0; i < 5; i++) vec("normal", O_NORMAL);
      chk_cnt("normal", 0, 0, 0, 0);

      // Three-cycle data stall, then advance on dhit.
      mem_dREN = 1'b1;
      for (int i = 0; i < 3; i++) vec("dstall", O_DSTALL);
      dhit = 1'b1;
      vec("dhit", O_NORMAL);
      chk_cnt("dstall", 3, 3, 0, 0);
      mem_dREN = 1'b0; dhit = 1'b0;

      // Load-use hazards.
      ex_dREN = 1'b1; ex_Rt = 5'd5; id_Rs = 5'd5;
      vec("lu_rs", O_LU);
      id_Rs = 5'd0; id_Rt = 5'd5; id_uses_Rt = 1'b1;
      vec("lu_rt", O_LU);
      id_uses_Rt = 1'b0;
      vec("lu_rt_unused", O_NORMAL);
      ex_Rt = 5'd0; id_Rs = 5'd0;
      vec("lu_r0", O_NORMAL);
      ex_Rt = 5'd7; id_Rs = 5'd7; ihit = 1'b0;
      vec("lu_noihit", O_LU);
      ex_dREN = 1'b0;
      vec("noihit", O_NOIHIT);
      ihit = 1'b1;
      chk_cnt("lu", 7, 7, 0, 0);

      // Redirect waits for ihit, and the flushes repeat until then.
      mem_redirect = 1'b1; ihit = 1'b0;
      vec("redir_wait", O_REDIR0);
      ihit = 1'b1;
      vec("redir_go", O_REDIR1);
      mem_redirect = 1'b0;
      chk_cnt("redir", 8, 8, 1, 1);

      // HALT is held behind a data stall, then it drains.
      mem_halt = 1'b1; mem_dREN = 1'b1;
      for (int i = 0; i < 2; i++) vec("halt_stall", O_DSTALL);
      dhit = 1'b1;
      vec("halt_entry", O_HENTRY);
      idle();
      chk("drain_halt", {31'd0, halt_a}, 32'd0);
      vec("drain", O_DRAIN);
      chk("halted_halt", {31'd0, halt_a}, 32'd1);
      mem_redirect = 1'b1; mem_dREN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         vec("halted", O_ZERO);
         chk("halted_hold", {31'd0, halt_a}, 32'd1);
      end
      chk_cnt("halted", 10, 10, 0 + 1, 1);

      // Reset out of HALTED.
      nRST = 1'b0; #1;
      chk("rst2_halt", {31'd0, halt_a}, 32'd0);
      chk_cnt("rst2", 0, 0, 0, 0);
      idle();
      #1 nRST = 1'b1;
      @(posedge CLK); #1;
      vec("after_rst2", O_NORMAL);

      // A long data stall saturates the 4-bit counter.
      mem_dREN = 1'b1;
      for (int i = 0; i < 20; i++) vec("long_dstall", O_DSTALL);
      chk_cnt("sat", 20, 15, 0, 0);

      // Reset in the middle of the stall.
      #2 nRST = 1'b0; #1;
      chk("rst3_ctl", {23'd0, obs_a}, {23'd0, O_ZERO});
      chk_cnt("rst3", 0, 0, 0, 0);
      idle();
      #1 nRST = 1'b1;
      @(posedge CLK); #1;
      vec("after_rst3", O_NORMAL);
      chk("rst3_halt", {31'd0, halt_a}, 32'd0);

      // Back-to-back redirects saturate the 4-bit flush counter.
      mem_redirect = 1'b1;
      for (int i = 0; i < 17; i++) vec("redir_run", O_REDIR1);
      chk_cnt("fsat", 0, 0, 17, 15);

      // When HALT and a redirect arrive together, HALT wins and no flush is counted.
      mem_halt = 1'b1;
      vec("halt_redir", O_HENTRY);
      idle();
      chk_cnt("halt_redir", 0, 0, 17, 15);
      vec("drain2", O_DRAIN);
      chk("halted2", {31'd0, halt_b}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
